// File: rtl/axi_mon_pkg.sv
// Shared constants and types for the AXI write-channel protocol monitor.
package axi_mon_pkg;

  localparam logic [2:0] ERR_WLAST_EARLY   = 3'd1;
  localparam logic [2:0] ERR_WLAST_MISSING = 3'd2;
  localparam logic [2:0] ERR_W_NO_AW       = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW      = 3'd4;
  localparam logic [2:0] ERR_B_NO_W        = 3'd5;
  localparam logic [2:0] ERR_BID_MISMATCH  = 3'd6;
  localparam logic [2:0] ERR_BRESP         = 3'd7;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } bresp_e;

  // IDs are carried zero-extended to a fixed width so the entry type is parameter-free.
  localparam int AW_ID_MAX = 16;

  typedef struct packed {
    logic [AW_ID_MAX-1:0] id;
    logic [7:0]           len;
  } aw_entry_t;

  function automatic logic [2:0] lowest_code(input logic [7:0] raised);
    lowest_code = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (raised[i]) lowest_code = 3'(i);
    end
  endfunction

endpackage

// File: rtl/axi_mon_fifo.sv
// Synchronous FIFO with wrap-bit pointers; used for both AW and B tracking queues.
module axi_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
              (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    count   = wr_ptr - rd_ptr;
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr[PTR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/axi_wr_monitor.sv
// Passive AXI write-channel checker: tracks AW/W/B ordering, flags protocol errors
// and keeps saturating completion statistics.
module axi_wr_monitor #(
  parameter int ID_W    = 4,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_W-1:0]           AWID,
  input  logic [7:0]                AWLEN,
  input  logic                      AWVALID,
  input  logic                      AWREADY,
  input  logic                      WLAST,
  input  logic                      WVALID,
  input  logic                      WREADY,
  input  logic [ID_W-1:0]           BID,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  input  logic                      BREADY,
  output logic                      err_valid,
  output logic [2:0]                err_code,
  output logic [7:0]                err_sticky,
  output logic [$clog2(MAX_OUT):0]  outstanding,
  output logic [CNT_W-1:0]          wr_done_cnt,
  output logic [CNT_W-1:0]          wr_err_cnt
);

  import axi_mon_pkg::*;

  localparam int OUT_W = $clog2(MAX_OUT) + 1;

  if ((DATA_W % 8) != 0 || MAX_OUT < 2 || (MAX_OUT & (MAX_OUT - 1)) != 0 ||
      ID_W > AW_ID_MAX) begin : g_param_check
    $error("axi_wr_monitor: unsupported parameter combination");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                 aw_hs, w_hs, b_hs;
  logic                 aw_full, aw_empty, b_full, b_empty;
  logic [OUT_W-1:0]     aw_count, b_count;
  aw_entry_t            aw_in, aw_dout, aw_head;
  logic [AW_ID_MAX-1:0] b_dout;
  logic [7:0]           beat;
  logic                 aw_drop, aw_ok, burst_open, w_use, last_exp, burst_close;
  logic                 aw_push, aw_pop, b_push, b_pop;
  logic [7:0]           err_raise;

  always_comb begin
    aw_hs       = AWVALID && AWREADY;
    w_hs        = WVALID && WREADY;
    b_hs        = BVALID && BREADY;
    // Every accepted burst sits in exactly one queue until its B arrives.
    outstanding = aw_count + b_count;
    aw_in       = '{id: AW_ID_MAX'(AWID), len: AWLEN};
    aw_drop     = aw_hs && (outstanding == OUT_W'(MAX_OUT) || aw_full);
    aw_ok       = aw_hs && !aw_drop;
    aw_head     = aw_empty ? aw_in : aw_dout;
    burst_open  = !aw_empty || aw_ok;
    w_use       = w_hs && burst_open;
    last_exp    = (beat == aw_head.len);
    burst_close = w_use && (WLAST || last_exp);
    // A bypassed burst that also closes skips the AW queue and goes straight to B.
    aw_push     = aw_ok && !(burst_close && aw_empty);
    aw_pop      = burst_close && !aw_empty;
    b_push      = burst_close && !b_full;
    b_pop       = b_hs && !b_empty;

    err_raise                    = '0;
    err_raise[ERR_WLAST_EARLY]   = w_use && WLAST && !last_exp;
    err_raise[ERR_WLAST_MISSING] = w_use && last_exp && !WLAST;
    err_raise[ERR_W_NO_AW]       = w_hs && !burst_open;
    err_raise[ERR_OVERFLOW]      = aw_drop;
    err_raise[ERR_B_NO_W]        = b_hs && b_empty;
    err_raise[ERR_BID_MISMATCH]  = b_pop && (b_dout != AW_ID_MAX'(BID));
    err_raise[ERR_BRESP]         = b_hs && (BRESP == RESP_SLVERR || BRESP == RESP_DECERR);
  end

  axi_mon_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(MAX_OUT)) u_aw_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_push),
    .din   (aw_in),
    .pop   (aw_pop),
    .dout  (aw_dout),
    .full  (aw_full),
    .empty (aw_empty),
    .count (aw_count)
  );

  axi_mon_fifo #(.WIDTH(AW_ID_MAX), .DEPTH(MAX_OUT)) u_b_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .din   (aw_head.id),
    .pop   (b_pop),
    .dout  (b_dout),
    .full  (b_full),
    .empty (b_empty),
    .count (b_count)
  );

  // Registered stage: errors and statistics appear one cycle after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat        <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      err_sticky  <= '0;
      wr_done_cnt <= '0;
      wr_err_cnt  <= '0;
    end else begin
      if (burst_close)  beat <= '0;
      else if (w_use)   beat <= beat + 8'd1;
      err_valid  <= |err_raise;
      err_code   <= lowest_code(err_raise);
      err_sticky <= err_sticky | err_raise;
      if (b_hs) begin
        if (err_raise[ERR_BRESP]) wr_err_cnt  <= sat_inc(wr_err_cnt);
        else                      wr_done_cnt <= sat_inc(wr_done_cnt);
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_monitor.sv
// Bench for axi_wr_monitor: directed vector table followed by randomized traffic
// checked against a queue-based transaction model.
module tb_axi_wr_monitor;

  localparam int ID_W    = 4;
  localparam int MAX_OUT = 8;
  localparam int CNT_W   = 4;
  localparam int OUT_W   = $clog2(MAX_OUT) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [ID_W-1:0] AWID, BID;
  logic [7:0] AWLEN;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [1:0] BRESP;
  logic err_valid;
  logic [2:0] err_code;
  logic [7:0] err_sticky;
  logic [OUT_W-1:0] outstanding;
  logic [CNT_W-1:0] wr_done_cnt, wr_err_cnt;

  always #5 clk = ~clk;

  axi_wr_monitor #(.ID_W(ID_W), .DATA_W(64), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
    .outstanding(outstanding), .wr_done_cnt(wr_done_cnt), .wr_err_cnt(wr_err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level reference model.
  typedef struct { int id; int len; } aw_t;
  aw_t m_awq[$];
  int  m_bq[$];
  int  m_beats, m_done, m_errc, m_sticky, m_ec;
  bit  m_ev;

  task automatic model_step();
    int bits;
    bit aw_acc, close, bypass_used;
    int cid, beat_no, h;
    aw_t cur, nw;
    if (rst) begin
      m_awq.delete(); m_bq.delete();
      m_beats = 0; m_done = 0; m_errc = 0; m_sticky = 0; m_ec = 0; m_ev = 0;
      return;
    end
    bits = 0; aw_acc = 0; close = 0; bypass_used = 0; cid = 0;
    nw = '{int'(AWID), int'(AWLEN)};
    if (AWVALID && AWREADY) begin
      if (m_awq.size() + m_bq.size() >= MAX_OUT) bits |= (1 << 4);
      else aw_acc = 1;
    end
    if (WVALID && WREADY) begin
      if (m_awq.size() == 0 && !aw_acc) bits |= (1 << 3);
      else begin
        cur = (m_awq.size() > 0) ? m_awq[0] : nw;
        beat_no = m_beats + 1;
        if (WLAST && beat_no != cur.len + 1) bits |= (1 << 1);
        if (!WLAST && beat_no == cur.len + 1) bits |= (1 << 2);
        if (WLAST || beat_no == cur.len + 1) begin
          close = 1; cid = cur.id; m_beats = 0;
          if (m_awq.size() > 0) void'(m_awq.pop_front());
          else bypass_used = 1;
        end else m_beats = beat_no;
      end
    end
    if (aw_acc && !bypass_used) m_awq.push_back(nw);
    if (BVALID && BREADY) begin
      if (m_bq.size() == 0) bits |= (1 << 5);
      else begin
        h = m_bq.pop_front();
        if (h != int'(BID)) bits |= (1 << 6);
      end
      if (BRESP >= 2) begin
        bits |= (1 << 7);
        if (m_errc < CNT_MAX) m_errc++;
      end else if (m_done < CNT_MAX) m_done++;
    end
    if (close) m_bq.push_back(cid);
    m_ev = (bits != 0);
    m_ec = 0;
    for (int i = 7; i >= 1; i--) if (bits[i]) m_ec = i;
    m_sticky |= bits;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    int r, aw, awid, awlen, w, wl, b, bid, bresp;
    int ev, ec, outs, done, errc, st;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input int r, aw, awid, awlen, w, wl, b, bid, bresp,
                              input int ev, ec, outs, done, errc, st);
    return '{r, aw, awid, awlen, w, wl, b, bid, bresp, ev, ec, outs, done, errc, st};
  endfunction

  initial begin
    int b_prob;
    rst = 1'b1; AWID = '0; AWLEN = '0; AWVALID = 0; AWREADY = 1; WLAST = 0;
    WVALID = 0; WREADY = 1; BID = '0; BRESP = '0; BVALID = 0; BREADY = 1;

    //              r aw id ln w wl b bid rsp | ev ec out done errc sticky
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk(0,1,3,3, 0,0, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,3,0,  0,0,0,1,0,0));
    vecs.push_back(mk(0,1,5,3, 0,0, 0,0,0,  0,0,1,1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,0,  0,0,1,1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1, 0,0,0,  1,1,1,1,0,2));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,5,0,  0,0,0,2,0,2));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk(0,1,2,0, 1,1, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,2,0,  0,0,0,1,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0,1,k,0, 0,0, 0,0,0,  0,0,k,0,0,0));
    vecs.push_back(mk(0,1,9,0, 0,0, 0,0,0,  1,4,8,0,0,16));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,  0,0,8,0,0,16));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0, 0,0, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,1,2,0, 0,0, 0,0,0,  0,0,2,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1, 0,0,0,  0,0,2,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,2,0,  1,6,1,1,0,64));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,1,0,  1,6,0,2,0,64));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk(0,1,4,0, 0,0, 0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1, 1,4,2,  1,5,1,0,1,160));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,4,0,  0,0,0,1,1,160));
    vecs.push_back(mk(0,0,0,0, 1,1, 0,0,0,  1,3,0,1,1,168));
    vecs.push_back(mk(0,1,1,1, 0,0, 0,0,0,  0,0,1,1,1,168));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,0,  0,0,1,1,1,168));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,0,  1,2,1,1,1,172));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,1,0,  0,0,0,2,1,172));
    vecs.push_back(mk(0,1,1,3, 0,0, 0,0,0,  0,0,1,2,1,172));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,0,  0,0,1,2,1,172));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,0,  1,3,0,0,0,8));
    vecs.push_back(mk(0,0,0,0, 1,1, 1,0,3,  1,3,0,0,1,168));

    foreach (vecs[i]) begin
      rst = vecs[i].r[0]; AWVALID = vecs[i].aw[0]; AWID = ID_W'(vecs[i].awid);
      AWLEN = 8'(vecs[i].awlen); WVALID = vecs[i].w[0]; WLAST = vecs[i].wl[0];
      BVALID = vecs[i].b[0]; BID = ID_W'(vecs[i].bid); BRESP = 2'(vecs[i].bresp);
      AWREADY = 1; WREADY = 1; BREADY = 1;
      step();
      check($sformatf("v%0d err_valid", i), int'(err_valid), vecs[i].ev);
      if (vecs[i].ev != 0) check($sformatf("v%0d err_code", i), int'(err_code), vecs[i].ec);
      check($sformatf("v%0d outstanding", i), int'(outstanding), vecs[i].outs);
      check($sformatf("v%0d wr_done_cnt", i), int'(wr_done_cnt), vecs[i].done);
      check($sformatf("v%0d wr_err_cnt", i), int'(wr_err_cnt), vecs[i].errc);
      check($sformatf("v%0d err_sticky", i), int'(err_sticky), vecs[i].st);
    end

    rst = 1; AWVALID = 0; WVALID = 0; BVALID = 0;
    step();
    rst = 0;
    for (int n = 0; n < 4000; n++) begin
      b_prob  = ((n / 400) % 2 != 0) ? 8 : 55;
      rst     = ($urandom_range(0, 999) == 0);
      AWVALID = ($urandom_range(0, 99) < 40);
      AWREADY = ($urandom_range(0, 99) < 70);
      AWID    = ID_W'($urandom);
      AWLEN   = 8'($urandom_range(0, 3));
      WVALID  = ($urandom_range(0, 99) < 50);
      WREADY  = ($urandom_range(0, 99) < 75);
      if (m_awq.size() > 0 && $urandom_range(0, 15) != 0)
        WLAST = (m_beats + 1 == m_awq[0].len + 1);
      else
        WLAST = $urandom_range(0, 1) != 0;
      BVALID  = ($urandom_range(0, 99) < b_prob);
      BREADY  = ($urandom_range(0, 99) < 80);
      BID     = (m_bq.size() > 0 && $urandom_range(0, 7) != 0) ? ID_W'(m_bq[0]) : ID_W'($urandom);
      BRESP   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step();
      check($sformatf("r%0d err_valid", n), int'(err_valid), int'(m_ev));
      if (m_ev) check($sformatf("r%0d err_code", n), int'(err_code), m_ec);
      check($sformatf("r%0d outstanding", n), int'(outstanding), m_awq.size() + m_bq.size());
      check($sformatf("r%0d wr_done_cnt", n), int'(wr_done_cnt), m_done);
      check($sformatf("r%0d wr_err_cnt", n), int'(wr_err_cnt), m_errc);
      check($sformatf("r%0d err_sticky", n), int'(err_sticky), m_sticky);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
